// File: rtl/fetch_unit_if.sv
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit_if                                              |
// | Description : Signal bundle for the instruction fetch stage: the          |
// |               instruction-memory read port, the valid/ready instruction   |
// |               output to the decoder, and the redirect input from execute.|
// |               master : fetch side (fetch_unit)                           |
// |               slave  : environment side (memory, decoder, execute)       |
// | Ports       : none (plain signal bundle)                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

interface fetch_unit_if;
  // instruction memory read port
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  // instruction output to register file / decoder
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  // control-flow redirect from execute
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid, fetch_fault,
    input  imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid, fetch_fault,
    output imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit                                                 |
// | Description : Instruction fetch stage. Holds the PC, issues word reads   |
// |               to instruction memory with at most one request            |
// |               outstanding, and buffers the returned word in a one-entry  |
// |               valid/ready output register. A redirect reloads the PC and |
// |               discards anything in flight.                               |
// | Ports       : clk   - rising-edge clock                                  |
// |               reset - asynchronous active-high reset                     |
// |               bus   - fetch_unit_if.master (imem port, instruction       |
// |                       output, redirect input, fetch_fault)               |
// | Options     : FETCH_ALIGN_CHECK_EN - when defined, a redirect to a       |
// |               non-word-aligned target enters a sticky FAULT state;       |
// |               otherwise the target is silently word-aligned.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic  clk,
  input  wire logic  reset,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
`ifdef FETCH_ALIGN_CHECK_EN
    S_FULL  = 3'd3,
    S_FAULT = 3'd4
`else
    S_FULL  = 3'd3
`endif
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic        r_drop, w_drop;          // one stale response still to drain
  logic [31:0] r_instr, w_instr;
  logic [31:0] r_instr_pc, w_instr_pc;
  logic        r_valid, w_valid;
  logic        w_req;
  logic        w_redir_live;
  logic [31:0] w_redir_aligned;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        r_fault, w_fault;
  // A faulted fetch unit ignores further redirects until reset.
  assign w_redir_live = bus.redirect && (r_state != S_FAULT);
`else
  assign w_redir_live = bus.redirect;
`endif

  assign w_redir_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_drop     = r_drop;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    w_valid    = r_valid;
    w_req      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    w_fault    = r_fault;
`endif

    case (r_state)
      S_IDLE: w_state = S_REQ;
      S_REQ: begin
        w_req   = 1'b1;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (r_drop) begin
            // response belongs to a request issued before a redirect
            w_drop  = 1'b0;
            w_state = S_REQ;
          end else begin
            w_instr    = bus.imem_rdata;
            w_instr_pc = r_pc;
            w_valid    = 1'b1;
            w_pc       = r_pc + 32'd4;
            w_state    = S_FULL;
          end
        end
      end
      S_FULL: begin
        // Issue the next fetch in the same cycle the buffer drains.
        if (bus.instr_ready) begin
          w_req   = 1'b1;
          w_valid = 1'b0;
          w_state = S_WAIT;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_FAULT: w_state = S_FAULT;
`endif
      default: w_state = S_IDLE;
    endcase

    // Redirect overrides whatever the state logic decided above.
    if (w_redir_live) begin
      w_req      = 1'b0;
      w_valid    = 1'b0;
      w_instr    = r_instr;
      w_instr_pc = r_instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        w_pc    = bus.redirect_pc;
        w_fault = 1'b1;
        w_drop  = 1'b0;
        w_state = S_FAULT;
      end else begin
`endif
        w_pc = w_redir_aligned;
        if ((r_state == S_WAIT) && !bus.imem_rvalid) begin
          // keep the outstanding request accounted for and drop it later
          w_drop  = 1'b1;
          w_state = S_WAIT;
        end else begin
          w_drop  = 1'b0;
          w_state = S_REQ;
        end
`ifdef FETCH_ALIGN_CHECK_EN
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= RESET_PC;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_drop     <= w_drop;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
      r_valid    <= w_valid;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_fault;
    end
  end
  assign bus.fetch_fault = r_fault;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instruction = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                              |
// | Description : Self-checking bench for fetch_unit. A memory model answers |
// |               requests with random latency; a monitor compares every     |
// |               accepted instruction against the program-order stream      |
// |               implied by reset and the queued redirect targets.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk;
  logic reset;

  fetch_unit_if bus_if ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_xfers  = 0;
  int          mem_lat_fixed = 1;   // 0 = random latency 1..3
  logic [31:0] redir_q[$];

  // Program image: the test-plan word at 0, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    bus_if.redirect    = 1'b1;
    bus_if.redirect_pc = t;
    redir_q.push_back(t);
  endtask

  task automatic wait_for_req(input string name);
    int k = 0;
    while (!bus_if.imem_req && k < 30) begin
      next_cycle();
      sample();
      k++;
    end
    if (!bus_if.imem_req) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_for_valid(input string name);
    int k = 0;
    while (!bus_if.instr_valid && k < 30) begin
      next_cycle();
      sample();
      k++;
    end
    if (!bus_if.instr_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- instruction memory model ----------------
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  initial begin
    bus_if.imem_rvalid = 1'b0;
    bus_if.imem_rdata  = 32'h0;
    mem_busy = 1'b0;
    mem_addr = 32'h0;
    mem_cnt  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_busy = 1'b0;
      end else if (bus_if.imem_req) begin
        mem_busy = 1'b1;
        mem_addr = bus_if.imem_addr;
        mem_cnt  = (mem_lat_fixed != 0) ? mem_lat_fixed : int'($urandom_range(1, 3));
      end
      @(posedge clk);
      #1;
      bus_if.imem_rvalid = 1'b0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus_if.imem_rvalid = 1'b1;
          bus_if.imem_rdata  = mem_word(mem_addr);
          mem_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] model_pc;
  int          outstanding;
  logic        prev_hold;
  logic [31:0] prev_instr, prev_pc;
  initial begin
    logic [31:0] t;
    model_pc    = RESET_PC;
    outstanding = 0;
    prev_hold   = 1'b0;
    prev_instr  = 32'h0;
    prev_pc     = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        model_pc    = RESET_PC;
        outstanding = 0;
        prev_hold   = 1'b0;
        redir_q.delete();
      end else begin
        if (bus_if.imem_rvalid && outstanding > 0) outstanding--;
        if (bus_if.imem_req) begin
          chk("one_outstanding", outstanding, 32'd0);
          outstanding++;
        end
        if (prev_hold) begin
          chk("hold_valid", {31'd0, bus_if.instr_valid}, 32'd1);
          chk("hold_instr", bus_if.instruction, prev_instr);
          chk("hold_pc", bus_if.instr_pc, prev_pc);
        end
        if (bus_if.instr_valid && bus_if.instr_ready) begin
          chk("xfer_pc", bus_if.instr_pc, model_pc);
          chk("xfer_instr", bus_if.instruction, mem_word(model_pc));
          model_pc = model_pc + 32'd4;
          n_xfers++;
        end
        if (bus_if.redirect) begin
          if (redir_q.size() == 0) begin
            chk("redir_queue", 32'd0, 32'd1);
          end else begin
            t = redir_q.pop_front();
            model_pc = t & 32'hFFFF_FFFC;
          end
        end
        prev_hold  = bus_if.instr_valid && !bus_if.instr_ready && !bus_if.redirect;
        prev_instr = bus_if.instruction;
        prev_pc    = bus_if.instr_pc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t;
    logic [31:0] hold_pc, hold_ins;
    reset = 1'b1;
    bus_if.instr_ready = 1'b1;
    bus_if.redirect    = 1'b0;
    bus_if.redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    sample();
    chk("rst_req", {31'd0, bus_if.imem_req}, 32'd0);
    chk("rst_addr", bus_if.imem_addr, RESET_PC);
    chk("rst_instr", bus_if.instruction, NOP_INSTR);
    chk("rst_ipc", bus_if.instr_pc, RESET_PC);
    chk("rst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, bus_if.fetch_fault}, 32'd0);
    reset = 1'b0;                         // cycle 0 (IDLE)
    #1 chk("c0_req", {31'd0, bus_if.imem_req}, 32'd0);

    // first fetch timing
    next_cycle(); sample();               // cycle 1
    chk("c1_req", {31'd0, bus_if.imem_req}, 32'd1);
    chk("c1_addr", bus_if.imem_addr, 32'h0);
    next_cycle(); sample();               // cycle 2
    chk("c2_req", {31'd0, bus_if.imem_req}, 32'd0);
    chk("c2_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    next_cycle(); sample();               // cycle 3
    chk("c3_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    chk("c3_instr", bus_if.instruction, 32'h0050_0093);
    chk("c3_ipc", bus_if.instr_pc, 32'h0);
    chk("c3_req", {31'd0, bus_if.imem_req}, 32'd1);
    chk("c3_addr", bus_if.imem_addr, 32'h4);

    // back-pressure: hold FULL for 5 cycles
    next_cycle();
    bus_if.instr_ready = 1'b0;
    sample();
    wait_for_valid("stall_fill");
    chk("stall_ipc", bus_if.instr_pc, 32'h4);
    chk("stall_instr", bus_if.instruction, mem_word(32'h4));
    hold_pc  = bus_if.instr_pc;
    hold_ins = bus_if.instruction;
    for (int j = 0; j < 5; j++) begin
      chk("stall_req", {31'd0, bus_if.imem_req}, 32'd0);
      chk("stall_hold_instr", bus_if.instruction, hold_ins);
      chk("stall_hold_pc", bus_if.instr_pc, hold_pc);
      if (j < 4) begin
        next_cycle(); sample();
      end
    end
    next_cycle();
    bus_if.instr_ready = 1'b1;
    mem_lat_fixed = 2;
    sample();
    chk("stall_release_req", {31'd0, bus_if.imem_req}, 32'd1);
    chk("stall_release_addr", bus_if.imem_addr, 32'h8);

    // redirect while waiting; stale response arrives a cycle later
    next_cycle();
    do_redirect(32'h100);
    sample();
    chk("rw_req", {31'd0, bus_if.imem_req}, 32'd0);
    next_cycle();
    bus_if.redirect = 1'b0;
    sample();
    chk("rw_drain_req", {31'd0, bus_if.imem_req}, 32'd0);
    chk("rw_drain_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    next_cycle();
    mem_lat_fixed = 1;
    sample();
    chk("rw_new_req", {31'd0, bus_if.imem_req}, 32'd1);
    chk("rw_new_addr", bus_if.imem_addr, 32'h100);
    wait_for_valid("rw_fill");
    chk("rw_ipc", bus_if.instr_pc, 32'h100);

    // redirect in the same cycle as the response
    next_cycle(); sample();
    wait_for_req("rv_req_wait");
    next_cycle();
    do_redirect(32'h200);
    sample();
    chk("rv_req", {31'd0, bus_if.imem_req}, 32'd0);
    next_cycle();
    bus_if.redirect = 1'b0;
    sample();
    chk("rv_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    chk("rv_req2", {31'd0, bus_if.imem_req}, 32'd1);
    chk("rv_addr", bus_if.imem_addr, 32'h200);

    // PC wrap
    next_cycle();
    do_redirect(32'hFFFF_FFFC);
    sample();
    next_cycle();
    bus_if.redirect = 1'b0;
    sample();
    wait_for_req("wrap_req1");
    chk("wrap_addr1", bus_if.imem_addr, 32'hFFFF_FFFC);
    next_cycle(); sample();
    wait_for_req("wrap_req2");
    chk("wrap_addr2", bus_if.imem_addr, 32'h0);

    // randomized traffic with one mid-run reset
    mem_lat_fixed = 0;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      bus_if.redirect    = 1'b0;
      bus_if.instr_ready = ($urandom_range(0, 9) < 7);
      if (i == 1500) begin
        reset = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        reset = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        t = $urandom;
        if (t[3]) t = t & 32'h0000_3FFF;
        else      t = t | 32'hFFFF_FF00;
`ifdef FETCH_ALIGN_CHECK_EN
        t[1:0] = 2'b00;
`endif
        do_redirect(t);
      end
    end
    next_cycle();
    bus_if.redirect    = 1'b0;
    bus_if.instr_ready = 1'b1;
    mem_lat_fixed = 1;
    chk("progress", {31'd0, (n_xfers > 100)}, 32'd1);

    // misaligned redirect
    next_cycle();
    do_redirect(32'h102);
    sample();
    next_cycle();
    bus_if.redirect = 1'b0;
    sample();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_addr", bus_if.imem_addr, 32'h102);
    for (int j = 0; j < 10; j++) begin
      chk("mis_fault", {31'd0, bus_if.fetch_fault}, 32'd1);
      chk("mis_req", {31'd0, bus_if.imem_req}, 32'd0);
      chk("mis_valid", {31'd0, bus_if.instr_valid}, 32'd0);
      next_cycle(); sample();
    end
`else
    wait_for_req("mis_req_wait");
    chk("mis_addr", bus_if.imem_addr, 32'h100);
    chk("mis_fault", {31'd0, bus_if.fetch_fault}, 32'd0);
`endif

    repeat (3) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RISC-V datapath, directly upstream of the register file/decoder. Holds the program counter, issues word reads to instruction memory with at most one request outstanding, and buffers the returned instruction in a one-entry valid/ready output register. A redirect input (branch/jump target from execute) reloads the PC and discards any instruction in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, value driven on `instruction` while empty after reset (addi x0,x0,0)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- imem_req  out  1  single-cycle read request to instruction memory
- imem_addr  out  32  read address, equals current PC
- imem_rvalid  in  1  read data valid, ≥1 cycle after imem_req, in order
- imem_rdata  in  32  instruction word
- instruction  out  32  buffered instruction to register file/decoder
- instr_pc  out  32  PC of `instruction`
- instr_valid  out  1  `instruction` is valid
- instr_ready  in  1  consumer accepts when instr_valid & instr_ready
- redirect  in  1  load new PC, flush fetch
- redirect_pc  in  32  new PC
- fetch_fault  out  1  misaligned redirect (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, FULL (+ FAULT with macro). Reset → IDLE.
- IDLE: imem_req=0; next state REQ unconditionally.
- REQ: imem_req=1, imem_addr=pc; next WAIT. imem_rvalid ignored in REQ.
- WAIT: imem_req=0. On imem_rvalid with drop=0: instruction<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 → FULL. With drop=1: discard data, clear drop → REQ.
- FULL: instr_valid=1. On instr_ready: imem_req=1 same cycle with imem_addr=pc, instr_valid<=0 → WAIT. Otherwise hold instruction/instr_pc stable.
- redirect has priority over everything in every state: pc<=redirect_pc, instr_valid<=0.
  - from IDLE/REQ/FULL → REQ; imem_req suppressed that cycle; handshake in FULL the same cycle still counts as a transfer to consumer.
  - from WAIT without imem_rvalid: stay WAIT, drop<=1 (keeps one outstanding).
  - from WAIT with imem_rvalid same cycle: data discarded, → REQ, drop stays 0.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- Reset values: imem_req 0, imem_addr RESET_PC, instruction NOP_INSTR, instr_pc RESET_PC, instr_valid 0, fetch_fault 0, drop 0.
- Reset mid-operation: all state cleared immediately; instruction memory shares the same reset, so no pre-reset response arrives afterward.

## Timing
- imem_req/imem_addr combinational from state, pc, instr_ready, redirect; instruction/instr_pc/instr_valid registered.
- Reset deasserted before edge 0: IDLE cycle 0, REQ cycle 1, earliest rvalid cycle 2, instr_valid cycle 3.
- Steady state with 1-cycle memory and instr_ready=1: one instruction per 2 cycles.
- Redirect at cycle N: request to redirect_pc at cycle N+1 earliest (N+1 after drained response if drop set).

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]≠0 → FAULT: fetch_fault=1 sticky, imem_req=0, instr_valid=0, imem_addr/pc=redirect_pc; exit only via reset. An outstanding response is discarded.
- Not defined: pc<={redirect_pc[31:2],2'b00}; fetch_fault tied 0; no FAULT state.

## Test plan
- Reset release, memory 1-cycle, word at 0x0 = 32'h00500093, instr_ready=1 -> imem_req at cycle 1 addr 0x0; instr_valid cycle 3 with instruction 32'h00500093, instr_pc 0x0; next imem_addr 0x4.
- instr_ready=0 for 5 cycles in FULL -> instruction/instr_pc stable, imem_req=0 throughout; request for pc+4 issued in cycle instr_ready rises.
- Redirect to 0x100 in WAIT, response 2 cycles later -> old response discarded, next imem_addr 0x100, first valid instr_pc 0x100.
- Redirect to 0x200 in same cycle as imem_rvalid -> data dropped, instr_valid stays 0, next request addr 0x200.
- Redirect to 0xFFFF_FFFC, then continue -> following request addr 0x0000_0000.
- Redirect to 0x102: with FETCH_ALIGN_CHECK_EN fetch_fault=1 and no further imem_req until reset; without, next request addr 0x100, fetch_fault=0.
